signed_seq_multiplier: RTL and testbench
========================================

# signed_seq_multiplier

Parametrised sequential shift-add multiplier, successor to the fixed 4x4 signed multiplier. Computes the full 2·WIDTH-bit product of two WIDTH-bit operands in WIDTH iterations, one iteration (conditional add/subtract plus shift) per clock. A per-operation `Signed_Mode` input selects two's-complement or unsigned arithmetic. A Start/Busy/Done handshake lets a controller or testbench issue back-to-back operations.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only when Busy=0.
- Signed_Mode  in  1  1 = operands are two's complement; 0 = operands are unsigned. Captured with Start.
- Multiplicand  in  WIDTH  operand M; captured when Start is accepted.
- Multiplier  in  WIDTH  operand Q; captured when Start is accepted.
- Product  out  2·WIDTH  registered result; held until the next result is written.
- Busy  out  1  high while an operation is iterating.
- Done  out  1  one-cycle pulse; Product is valid in the same cycle.

## Operation
- FSM states and transitions:
  - IDLE: waits for a request. On Start=1, go to RUN.
  - RUN: performs one iteration per clock for WIDTH cycles, then goes to DONE.
  - DONE: lasts one cycle. On Start=1, go to RUN; otherwise go to IDLE.
- Start is accepted in IDLE or DONE. In RUN, Start is ignored: the operands are not recaptured and the operation is not restarted.
- On acceptance the block loads:
  - Mext (WIDTH+1 bits): the multiplicand, sign-extended if Signed_Mode=1, zero-extended otherwise.
  - RegQ ← Multiplier.
  - RegA (WIDTH+1 bits) ← 0.
  - Count ← 0; Count is a $clog2(WIDTH)-bit iteration counter.
  - The mode bit is latched for the whole operation.
- Iteration i, for i = 0..WIDTH-1:
  - sum = RegA − Mext if RegQ[0]=1, latched mode is signed, and i = WIDTH-1.
  - sum = RegA + Mext if RegQ[0]=1 otherwise.
  - sum = RegA if RegQ[0]=0.
  - Width rules: sum is WIDTH+1 bits; no overflow is possible in either mode.
  - Shift: {RegA, RegQ} ← {fill, sum, RegQ[WIDTH-1:1]} (one bit right). fill = sum[WIDTH] in signed mode (arithmetic shift); fill = 0 in unsigned mode.
  - Count increments each iteration. Count = WIDTH-1 marks the last iteration.
- Result: on the last iteration edge, Product ← {RegA[WIDTH-1:0], RegQ} using the post-shift values.
- Product must equal the exact product under the latched mode:
  - signed range −2^(2W-2)+2^(W-1) .. 2^(2W-2);
  - unsigned range 0 .. (2^W−1)².
- Product is unchanged during RUN; it holds the previous result until the new one is written.

## Timing
- Reset (asynchronous, Reset=0): FSM goes to IDLE and the outputs are cleared immediately:
  - Product = 0, Busy = 0, Done = 0;
  - RegA, RegQ and Count = 0.
- Reset mid-operation: the operation is aborted immediately. No Done pulse is produced and Product reads 0.
- Reset release: Start is first sampled on the first rising edge after Reset goes high.
- Cycle numbering: Start is accepted at edge E0. Iterations occur at edges E1..EW.
- Busy:
  - goes high after E0;
  - stays high for exactly WIDTH cycles;
  - falls after EW.
- Done and Product:
  - Done is high for exactly one cycle, the cycle following EW.
  - Product is updated at EW.
- Latency: Start to Done is WIDTH+1 cycles measured from the Start cycle.
- Back-to-back: Start=1 during the DONE cycle is accepted at that edge. Busy then rises in the next cycle with no IDLE gap, giving a throughput of one result per WIDTH+1 cycles.
- Operand and mode inputs are don't-care except at the accepting edge.

## Test plan
- WIDTH=4, signed: 7 × −8 (0x7, 0x8) → Product 0xC8 (−56). Done arrives 5 cycles after Start; Busy is high for 4 cycles.
- WIDTH=4, signed: −8 × −8 → 0x40 (+64). Then unsigned 15 × 15 → 0xE1 (225), issued back-to-back in the DONE cycle. Check both results and that Busy has no gap.
- WIDTH=4, signed: −1 × 1 → 0xFF. Then 0 × −5 → 0x00. Product must hold 0xFF until the second Done.
- WIDTH=4: Start pulsed with new operands during RUN → ignored; the result belongs to the original operands, with exactly one Done pulse.
- WIDTH=4: Reset driven low at iteration 2, between clock edges → Busy, Done and Product are 0 immediately. A fresh 3 × 3 after release returns 0x09.
- WIDTH=8, signed: −128 × −128 → 0x4000; 127 × −128 → 0xC080. Unsigned 255 × 255 → 0xFE01. Random 1000-vector sweep in both modes checked against a reference model.

Source files
------------

// File: rtl/signed_seq_multiplier.sv
// signed_seq_multiplier
// Sequential shift-add multiplier producing the full 2*WIDTH-bit product of
// two WIDTH-bit operands, one add/subtract-and-shift iteration per clock.
// Signed_Mode selects two's-complement (1) or unsigned (0) arithmetic and is
// latched with the operands when Start is accepted in IDLE or DONE.
// In signed mode the final iteration subtracts the multiplicand, because the
// multiplier's MSB carries negative weight.

module signed_seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 accept_s;
    logic                 last_s;

    logic [WIDTH:0]       mext_r;
    logic [WIDTH:0]       reg_a_r;
    logic [WIDTH-1:0]     reg_q_r;
    logic [CW-1:0]        count_r;
    logic                 mode_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH:0]       sum_s;
    logic                 fill_s;
    logic [WIDTH:0]       next_a_s;
    logic [WIDTH-1:0]     next_q_s;

    assign Product = product_r;
    assign Busy    = busy_r;
    assign Done    = done_r;

    // State register for the IDLE/RUN/DONE controller.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; Start is only accepted while not iterating.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One iteration: conditional add/subtract of the extended multiplicand, then a one-bit right shift of {A,Q}.
    always_comb begin
        last_s = (count_r == LAST_COUNT);
        if (reg_q_r[0]) begin
            if (mode_r && last_s) begin
                sum_s = reg_a_r - mext_r;
            end else begin
                sum_s = reg_a_r + mext_r;
            end
        end else begin
            sum_s = reg_a_r;
        end
        if (mode_r) begin
            fill_s = sum_s[WIDTH];
        end else begin
            fill_s = 1'b0;
        end
        next_a_s = {fill_s, sum_s[WIDTH:1]};
        next_q_s = {sum_s[0], reg_q_r[WIDTH-1:1]};
    end

    // Datapath registers: operand capture on accept, iteration while running, result on the last iteration.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mext_r    <= {(WIDTH+1){1'b0}};
            reg_a_r   <= {(WIDTH+1){1'b0}};
            reg_q_r   <= {WIDTH{1'b0}};
            count_r   <= {CW{1'b0}};
            mode_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            if (Signed_Mode) begin
                mext_r <= {Multiplicand[WIDTH-1], Multiplicand};
            end else begin
                mext_r <= {1'b0, Multiplicand};
            end
            reg_a_r <= {(WIDTH+1){1'b0}};
            reg_q_r <= Multiplier;
            count_r <= {CW{1'b0}};
            mode_r  <= Signed_Mode;
        end else if (state_r == ST_RUN) begin
            reg_a_r <= next_a_s;
            reg_q_r <= next_q_s;
            count_r <= count_r + COUNT_ONE;
            if (last_s) begin
                product_r <= {next_a_s[WIDTH-1:0], next_q_s};
            end
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed and randomised checks of signed_seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_signed_seq_multiplier;

    logic        clk;
    logic        rst_n;

    logic        start4;
    logic        mode4;
    logic [3:0]  m4;
    logic [3:0]  q4;
    logic [7:0]  product4;
    logic        busy4;
    logic        done4;

    logic        start8;
    logic        mode8;
    logic [7:0]  m8;
    logic [7:0]  q8;
    logic [15:0] product8;
    logic        busy8;
    logic        done8;

    int checks;
    int errors;

    signed_seq_multiplier #(.WIDTH(4)) u_dut4 (
        .Clock        (clk),
        .Reset        (rst_n),
        .Start        (start4),
        .Signed_Mode  (mode4),
        .Multiplicand (m4),
        .Multiplier   (q4),
        .Product      (product4),
        .Busy         (busy4),
        .Done         (done4)
    );

    signed_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .Clock        (clk),
        .Reset        (rst_n),
        .Start        (start8),
        .Signed_Mode  (mode8),
        .Multiplicand (m8),
        .Multiplier   (q8),
        .Product      (product8),
        .Busy         (busy8),
        .Done         (done8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input int w, input logic mode, input logic [7:0] m, input logic [7:0] q);
        if (w == 4) begin
            start4 = 1'b1;
            mode4  = mode;
            m4     = m[3:0];
            q4     = q[3:0];
        end else begin
            start8 = 1'b1;
            mode8  = mode;
            m8     = m;
            q8     = q;
        end
    endtask

    task automatic clear_start(input int w);
        if (w == 4) begin
            start4 = 1'b0;
        end else begin
            start8 = 1'b0;
        end
    endtask

    task automatic sample(input int w, output logic d, output logic b, output logic [15:0] p);
        if (w == 4) begin
            d = done4;
            b = busy4;
            p = {8'h00, product4};
        end else begin
            d = done8;
            b = busy8;
            p = product8;
        end
    endtask

    // Called at the negedge where Start has just been driven. Checks latency,
    // Busy length, Product holding its old value, and the new result.
    // pulse_at > 0 re-asserts Start with other operands in that RUN cycle.
    task automatic wait_done(input int w, input string tag, input logic [15:0] exp_p,
                             input logic [15:0] hold_p, input int pulse_at);
        int          lat;
        int          busy_cnt;
        logic        seen;
        logic        hold_ok;
        logic        d;
        logic        b;
        logic [15:0] p;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        hold_ok  = 1'b1;
        d        = 1'b0;
        b        = 1'b0;
        p        = 16'h0000;
        while (!seen && lat < 4 * w + 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) clear_start(w);
            if (pulse_at > 0 && lat == pulse_at) begin
                start_op(w, 1'b0, 8'h03, 8'h03);
            end else if (pulse_at > 0 && lat == pulse_at + 1) begin
                clear_start(w);
            end
            sample(w, d, b, p);
            if (d) begin
                seen = 1'b1;
            end else begin
                if (b) busy_cnt++;
                if (p !== hold_p) hold_ok = 1'b0;
            end
        end
        check_value({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_value({tag, "_latency"}, 64'(lat), 64'(w + 1));
        check_value({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(w));
        check_value({tag, "_busy_at_done"}, 64'(b), 64'd0);
        check_value({tag, "_product_hold"}, 64'(hold_ok), 64'd1);
        check_value({tag, "_product"}, 64'(p), 64'(exp_p));
    endtask

    task automatic check_idle(input int w, input string tag, input int cycles);
        logic        d;
        logic        b;
        logic [15:0] p;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sample(w, d, b, p);
            check_value({tag, "_idle_done"}, 64'(d), 64'd0);
            check_value({tag, "_idle_busy"}, 64'(b), 64'd0);
        end
    endtask

    function automatic logic [15:0] ref_mul8(input logic mode, input logic [7:0] m, input logic [7:0] q);
        int a;
        int b;
        int r;
        if (mode) begin
            a = int'($signed(m));
            b = int'($signed(q));
        end else begin
            a = int'(m);
            b = int'(q);
        end
        r = a * b;
        return r[15:0];
    endfunction

    // Main stimulus sequence.
    initial begin
        logic        rmode;
        logic [7:0]  rm;
        logic [7:0]  rq;
        logic [15:0] rexp;
        logic [15:0] hold8;
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        start4 = 1'b0; mode4 = 1'b0; m4 = 4'h0; q4 = 4'h0;
        start8 = 1'b0; mode8 = 1'b0; m8 = 8'h00; q8 = 8'h00;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_value("reset_product4", 64'(product4), 64'h0);
        check_value("reset_busy4", 64'(busy4), 64'h0);
        check_value("reset_done4", 64'(done4), 64'h0);
        check_value("reset_product8", 64'(product8), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 7 x -8 signed
        start_op(4, 1'b1, 8'h07, 8'h08);
        wait_done(4, "s7xm8", 16'h00C8, 16'h0000, 0);
        check_idle(4, "s7xm8", 1);

        // -8 x -8 signed, then unsigned 15 x 15 back-to-back in DONE
        start_op(4, 1'b1, 8'h08, 8'h08);
        wait_done(4, "sm8xm8", 16'h0040, 16'h00C8, 0);
        start_op(4, 1'b0, 8'h0F, 8'h0F);
        wait_done(4, "u15x15", 16'h00E1, 16'h0040, 0);
        check_idle(4, "u15x15", 1);

        // -1 x 1 then 0 x -5; product holds 0xFF until second Done
        start_op(4, 1'b1, 8'h0F, 8'h01);
        wait_done(4, "sm1x1", 16'h00FF, 16'h00E1, 0);
        check_idle(4, "sm1x1", 1);
        start_op(4, 1'b1, 8'h00, 8'h0B);
        wait_done(4, "s0xm5", 16'h0000, 16'h00FF, 0);
        check_idle(4, "s0xm5", 1);

        // Start pulsed during RUN must be ignored
        start_op(4, 1'b1, 8'h02, 8'h03);
        wait_done(4, "ignore", 16'h0006, 16'h0000, 2);
        check_idle(4, "ignore", 4);

        // Reset between clock edges at iteration 2
        start_op(4, 1'b1, 8'h05, 8'h03);
        @(negedge clk);
        clear_start(4);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("midrst_busy4", 64'(busy4), 64'h0);
        check_value("midrst_done4", 64'(done4), 64'h0);
        check_value("midrst_product4", 64'(product4), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("midrst_still_idle", 64'({busy4, done4}), 64'h0);
        start_op(4, 1'b1, 8'h03, 8'h03);
        wait_done(4, "rst_3x3", 16'h0009, 16'h0000, 0);
        check_idle(4, "rst_3x3", 1);

        // WIDTH=8 boundary vectors, chained back-to-back
        start_op(8, 1'b1, 8'h80, 8'h80);
        wait_done(8, "w8_m128xm128", 16'h4000, 16'h0000, 0);
        start_op(8, 1'b1, 8'h7F, 8'h80);
        wait_done(8, "w8_127xm128", 16'hC080, 16'h4000, 0);
        start_op(8, 1'b0, 8'hFF, 8'hFF);
        wait_done(8, "w8_u255x255", 16'hFE01, 16'hC080, 0);
        hold8 = 16'hFE01;

        // Random sweep in both modes against the reference model
        for (int i = 0; i < 1000; i++) begin
            rmode = 1'($urandom_range(0, 1));
            rm    = 8'($urandom_range(0, 255));
            rq    = 8'($urandom_range(0, 255));
            rexp  = ref_mul8(rmode, rm, rq);
            start_op(8, rmode, rm, rq);
            wait_done(8, $sformatf("rnd%0d", i), rexp, hold8, 0);
            hold8 = rexp;
        end
        check_idle(8, "rnd_end", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
